regfile_sb: RTL and testbench

- Parametrised multi-write-port register file for the next-generation RISC core.
- Two combinational read ports and two write ports:
  - port A: ALU writeback.
  - port L: load writeback.
- Per-register pending-load scoreboard that raises a stall to the decode stage when a source register awaits a load.
- Sits between decode (reads), execute (port A) and memory (port L).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 62 ++++++
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, index type and hardwired-index helper for the register file.
package regfile_pkg;

    localparam int unsigned RF_WIDTH_DEF = 16;
    localparam int unsigned RF_DEPTH_DEF = 16;
    localparam int unsigned RF_AW_DEF    = $clog2(RF_DEPTH_DEF);

    typedef logic [RF_AW_DEF-1:0] rf_idx_t;

    // Index 0 is always zero; the top index is all-ones when hard_ones_top is set.
    function automatic logic is_hardwired(input int unsigned idx,
                                          input int unsigned depth,
                                          input int unsigned hard_ones_top);
        return (idx == 0) || ((hard_ones_top != 0) && (idx == depth - 1));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register plus the decode stall.
// With REGFILE_BYPASS_EN a load completing this cycle releases the stall immediately.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH         = RF_DEPTH_DEF,
    parameter int unsigned HARD_ONES_TOP = 1,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    input  logic             use1,
    input  logic             use2,
    input  logic             wel,
    input  logic [AW-1:0]    wrl,
    input  logic             pend_set,
    input  logic [AW-1:0]    pend_idx,
    output logic             stall,
    output logic [DEPTH-1:0] pend_vec
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             clr1;
    logic             clr2;

    // Set beats clear; hardwired indices never become pending.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pend_set && (pend_idx == AW'(i)) && !is_hardwired(i, DEPTH, HARD_ONES_TOP)) begin
                pend_d[i] = 1'b1;
            end else if (wel && (wrl == AW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        clr1 = wel && (wrl == rr1);
        clr2 = wel && (wrl == rr2);
`else
        clr1 = 1'b0;
        clr2 = 1'b0;
`endif
        stall = (use1 && pend_q[rr1] && !clr1) || (use2 && pend_q[rr2] && !clr2);
    end

    assign pend_vec = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with pending-load scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH         = RF_WIDTH_DEF,
    parameter int unsigned DEPTH         = RF_DEPTH_DEF,
    parameter int unsigned HARD_ONES_TOP = 1,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    input  logic             use1,
    input  logic             use2,
    output logic [WIDTH-1:0] dr1,
    output logic [WIDTH-1:0] dr2,
    input  logic             wea,
    input  logic [AW-1:0]    wra,
    input  logic [WIDTH-1:0] wda,
    input  logic             wel,
    input  logic [AW-1:0]    wrl,
    input  logic [WIDTH-1:0] wdl,
    input  logic             pend_set,
    input  logic [AW-1:0]    pend_idx,
    output logic             stall,
    output logic [DEPTH-1:0] pend_vec
);

    localparam logic [AW-1:0] TOP_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Port L first so port A (younger instruction) overrides on a collision.
    always_comb begin
        mem_d = mem_q;
        if (wel && !is_hardwired(32'(wrl), DEPTH, HARD_ONES_TOP)) begin
            mem_d[wrl] = wdl;
        end
        if (wea && !is_hardwired(32'(wra), DEPTH, HARD_ONES_TOP)) begin
            mem_d[wra] = wda;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read muxes: hardwired indices override both storage and forwarding.
    always_comb begin
        dr1 = mem_q[rr1];
        dr2 = mem_q[rr2];
`ifdef REGFILE_BYPASS_EN
        if (wel && (wrl == rr1)) dr1 = wdl;
        if (wea && (wra == rr1)) dr1 = wda;
        if (wel && (wrl == rr2)) dr2 = wdl;
        if (wea && (wra == rr2)) dr2 = wda;
`endif
        if (rr1 == '0) begin
            dr1 = '0;
        end else if ((HARD_ONES_TOP != 0) && (rr1 == TOP_IDX)) begin
            dr1 = '1;
        end
        if (rr2 == '0) begin
            dr2 = '0;
        end else if ((HARD_ONES_TOP != 0) && (rr2 == TOP_IDX)) begin
            dr2 = '1;
        end
    end

    rf_scoreboard #(
        .DEPTH         (DEPTH),
        .HARD_ONES_TOP (HARD_ONES_TOP)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rr1      (rr1),
        .rr2      (rr2),
        .use1     (use1),
        .use2     (use2),
        .wel      (wel),
        .wrl      (wrl),
        .pend_set (pend_set),
        .pend_idx (pend_idx),
        .stall    (stall),
        .pend_vec (pend_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: array-based reference model checked every negedge, plus directed literal checks.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    rf_idx_t     rr1 = '0, rr2 = '0, wra = '0, wrl = '0, pend_idx = '0;
    logic        use1 = 1'b0, use2 = 1'b0, wea = 1'b0, wel = 1'b0, pend_set = 1'b0;
    logic [15:0] wda = '0, wdl = '0;
    logic [15:0] dr1, dr2;
    logic        stall;
    logic [15:0] pend_vec;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_mem  [16];
    logic        m_pend [16];

    regfile_sb #(.WIDTH(16), .DEPTH(16), .HARD_ONES_TOP(1)) dut (
        .clk(clk), .rst_n(rst_n), .rr1(rr1), .rr2(rr2), .use1(use1), .use2(use2),
        .dr1(dr1), .dr2(dr2), .wea(wea), .wra(wra), .wda(wda), .wel(wel), .wrl(wrl),
        .wdl(wdl), .pend_set(pend_set), .pend_idx(pend_idx), .stall(stall), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bypass_on();
`ifdef REGFILE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Architectural view of a read: r0 = 0, r15 = all-ones, else latest (optionally forwarded) value.
    function automatic logic [15:0] exp_rd(input int idx);
        if (idx == 0) return 16'h0000;
        if (idx == 15) return 16'hFFFF;
        if (bypass_on() && wea && int'(wra) == idx) return wda;
        if (bypass_on() && wel && int'(wrl) == idx) return wdl;
        return m_mem[idx];
    endfunction

    function automatic logic exp_stall();
        logic s1, s2;
        s1 = use1 && m_pend[rr1] && !(bypass_on() && wel && wrl == rr1);
        s2 = use2 && m_pend[rr2] && !(bypass_on() && wel && wrl == rr2);
        return s1 || s2;
    endfunction

    function automatic logic [15:0] exp_pvec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Reference model: architectural state after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  = 16'h0000;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wel && wrl != 4'd0 && wrl != 4'd15) m_mem[wrl] = wdl;
            if (wea && wra != 4'd0 && wra != 4'd15) m_mem[wra] = wda;
            if (wel) m_pend[wrl] = 1'b0;
            if (pend_set && pend_idx != 4'd0 && pend_idx != 4'd15) m_pend[pend_idx] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_dr1", 32'(dr1), 32'(exp_rd(int'(rr1))));
            chk("model_dr2", 32'(dr2), 32'(exp_rd(int'(rr2))));
            chk("model_stall", 32'(stall), 32'(exp_stall()));
            chk("model_pend_vec", 32'(pend_vec), 32'(exp_pvec()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wea = 1'b0; wel = 1'b0; pend_set = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_pend_vec", 32'(pend_vec), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_dr1", 32'(dr1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read every index after reset.
        for (int i = 0; i < 16; i++) begin
            tick();
            rr1 = rf_idx_t'(i);
            rr2 = rf_idx_t'(15 - i);
            #1;
            chk("reset_read_dr1", 32'(dr1), (i == 15) ? 32'hFFFF : 32'h0);
            chk("reset_read_dr2", 32'(dr2), (i == 0) ? 32'hFFFF : 32'h0);
        end

        // Port A write, visible next cycle (same cycle only with forwarding).
        tick();
        wea = 1'b1; wra = 4'd3; wda = 16'h1234; rr1 = 4'd3; rr2 = 4'd0;
        #1;
        chk("wr_same_cycle", 32'(dr1), bypass_on() ? 32'h1234 : 32'h0);
        tick();
        idle();
        #1;
        chk("wr_next_cycle", 32'(dr1), 32'h1234);

        // Port A wins a collision with port L.
        tick();
        wea = 1'b1; wra = 4'd5; wda = 16'hAAAA;
        wel = 1'b1; wrl = 4'd5; wdl = 16'h5555; rr1 = 4'd5;
        tick();
        idle();
        #1;
        chk("collision_r5", 32'(dr1), 32'hAAAA);

        // Writes to hardwired indices are discarded.
        tick();
        wea = 1'b1; wra = 4'd0; wda = 16'hBEEF;
        wel = 1'b1; wrl = 4'd15; wdl = 16'hBEEF;
        rr1 = 4'd0; rr2 = 4'd15;
        #1;
        chk("hw_r0_same", 32'(dr1), 32'h0);
        chk("hw_r15_same", 32'(dr2), 32'hFFFF);
        tick();
        idle();
        #1;
        chk("hw_r0", 32'(dr1), 32'h0);
        chk("hw_r15", 32'(dr2), 32'hFFFF);

        // Pending load on r7 stalls a consumer until the load writes back.
        tick();
        pend_set = 1'b1; pend_idx = 4'd7;
        tick();
        idle();
        rr2 = 4'd7; use2 = 1'b1;
        #1;
        chk("pend7_set", 32'(pend_vec[7]), 32'h1);
        chk("stall_use2", 32'(stall), 32'h1);
        use2 = 1'b0;
        #1;
        chk("stall_nouse", 32'(stall), 32'h0);
        use2 = 1'b1; wel = 1'b1; wrl = 4'd7; wdl = 16'h00FF;
        #1;
        chk("stall_ld_cycle", 32'(stall), bypass_on() ? 32'h0 : 32'h1);
        chk("dr2_ld_cycle", 32'(dr2), bypass_on() ? 32'h00FF : 32'h0);
        tick();
        idle();
        #1;
        chk("pend7_clr", 32'(pend_vec[7]), 32'h0);
        chk("stall_after_ld", 32'(stall), 32'h0);
        chk("dr2_after_ld", 32'(dr2), 32'h00FF);
        use2 = 1'b0;

        // Set and clear on r9 in one cycle: set wins. Hardwired indices never pend.
        tick();
        pend_set = 1'b1; pend_idx = 4'd9; wel = 1'b1; wrl = 4'd9; wdl = 16'h1111;
        tick();
        idle();
        pend_set = 1'b1; pend_idx = 4'd0;
        tick();
        pend_idx = 4'd15;
        tick();
        idle();
        #1;
        chk("pend9_kept", 32'(pend_vec), 32'h0200);
        rr1 = 4'd9; use1 = 1'b1;
        #1;
        chk("stall_use1", 32'(stall), 32'h1);

        // Port A write to a pending register leaves the bit set.
        tick();
        wea = 1'b1; wra = 4'd9; wda = 16'h9999;
        tick();
        idle();
        #1;
        chk("porta_no_clear", 32'(pend_vec[9]), 32'h1);
        chk("porta_r9", 32'(dr1), 32'h9999);
        use1 = 1'b0;

        // Asynchronous reset mid-cycle clears storage and scoreboard without an edge.
        tick();
        wea = 1'b1; wra = 4'd4; wda = 16'h4444; pend_set = 1'b1; pend_idx = 4'd4;
        tick();
        idle();
        rr1 = 4'd4; use1 = 1'b1; rr2 = 4'd3;
        #1;
        chk("pre_rst_r4", 32'(dr1), 32'h4444);
        chk("pre_rst_pend4", 32'(pend_vec[4]), 32'h1);
        wea = 1'b1; wra = 4'd6; wda = 16'h6666;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r4", 32'(dr1), 32'h0);
        chk("async_rst_r3", 32'(dr2), 32'h0);
        chk("async_rst_pvec", 32'(pend_vec), 32'h0);
        chk("async_rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        rr2 = 4'd6;
        tick();
        chk("inflight_lost", 32'(dr2), 32'h0);
        use1 = 1'b0;

        // Short directed burst for the per-cycle model compare.
        for (int i = 1; i < 15; i++) begin
            tick();
            wea = 1'b1; wra = rf_idx_t'(i); wda = 16'(16'h1000 + 16'(i * 17));
            wel = (i % 3) == 0; wrl = rf_idx_t'(15 - i); wdl = 16'(16'h8000 + 16'(i));
            pend_set = (i % 2) == 0; pend_idx = rf_idx_t'(i + 1);
            rr1 = rf_idx_t'(i); rr2 = rf_idx_t'(15 - i);
            use1 = 1'b1; use2 = (i % 2) == 1;
        end
        tick();
        idle();
        use1 = 1'b0; use2 = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
